// File: rtl/shift_sequencer.sv
// shift_sequencer: multi-cycle front end for a 64-bit logical-right barrel
// shifter that can only move 0..31 bits per pass. A 6-bit shift amount is
// split into up to two fixed 16-bit passes (amt[5]) plus one pass of amt[4:0].
// Left shifts reverse the operand on the way in and the result on the way out.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   in_valid/in_ready   operand handshake (ready only in IDLE)
//   in_data/amt/left    operand, shift amount 0..63, 1 = left
//   sh_din/sh_samt      drive the external combinational shifter
//   sh_dout             shifter result, settles within one cycle
//   out_valid/out_ready result handshake (valid only in DONE)
//   out_data            shifted result, held stable under backpressure
module shift_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_data,
  input  logic [5:0]  in_amt,
  input  logic        in_left,
  output logic [63:0] sh_din,
  output logic [4:0]  sh_samt,
  input  logic [63:0] sh_dout,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data
);

  typedef enum logic [2:0] {IDLE, HI0, HI1, LO, DONE} state_t;

  state_t      state;
  logic [63:0] wr;
  logic [4:0]  lo;
  logic        dir;

  function automatic logic [63:0] bitrev(input logic [63:0] x);
    logic [63:0] r;
    for (int i = 0; i < 64; i++) r[i] = x[63-i];
    return r;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      wr    <= '0;
      lo    <= '0;
      dir   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          wr    <= in_left ? bitrev(in_data) : in_data;
          lo    <= in_amt[4:0];
          dir   <= in_left;
          state <= in_amt[5] ? HI0 : LO;
        end
        // Two 16-bit passes make up the 32-bit component of the amount.
        HI0: begin wr <= sh_dout; state <= HI1; end
        HI1: begin wr <= sh_dout; state <= LO;  end
        // Runs even for lo == 0 so timing depends only on amt[5].
        LO:  begin wr <= sh_dout; state <= DONE; end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // All outputs decode registered state only; nothing combinational from inputs.
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    sh_din    = wr;
    sh_samt   = 5'd0;
    case (state)
      HI0, HI1: sh_samt = 5'd16;
      LO:       sh_samt = lo;
      default:  sh_samt = 5'd0;
    endcase
    out_data = (state == DONE) ? (dir ? bitrev(wr) : wr) : 64'd0;
  end

endmodule

// File: tb/tb_shift_sequencer.sv
module tb_shift_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_data = '0;
  logic [5:0]  in_amt = '0;
  logic        in_left = 1'b0;
  logic [63:0] sh_din;
  logic [4:0]  sh_samt;
  logic [63:0] sh_dout;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;

  shift_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_amt(in_amt), .in_left(in_left),
    .sh_din(sh_din), .sh_samt(sh_samt), .sh_dout(sh_dout),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  // combinational barrel shifter model
  assign sh_dout = sh_din >> sh_samt;

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // out_ready source: forced level or random
  logic rdy_rand = 1'b0;
  logic rdy_force = 1'b1;
  logic rnd = 1'b1;
  always @(posedge clk) begin
    #1;
    rnd = 1'($urandom_range(0, 1));
  end
  always @* out_ready = rdy_rand ? rnd : rdy_force;

  // scoreboard
  typedef struct {
    logic [63:0] data;
    int          due;
  } exp_t;
  exp_t sb[$];
  logic        seen = 1'b0;
  logic [63:0] held = '0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid) begin
        if (sb.size() == 0) chk("spurious_valid", 64'd1, 64'd0);
        else begin
          if (!seen) begin
            chk("latency", 64'(cyc), 64'(sb[0].due));
            chk("data", out_data, sb[0].data);
            held = out_data;
            seen = 1'b1;
          end else chk("hold", out_data, held);
          if (out_ready) begin
            void'(sb.pop_front());
            seen = 1'b0;
          end
        end
      end
      if (in_valid && in_ready) begin
        exp_t e;
        e.data = in_left ? (in_data << in_amt) : (in_data >> in_amt);
        e.due  = cyc + (in_amt[5] ? 4 : 2);
        sb.push_back(e);
      end
    end
  end

  // present operand from posedge+1, returns at posedge+1 after the accept edge
  task automatic send(input logic [63:0] d, input logic [5:0] a, input logic l);
    int n;
    in_valid = 1'b1; in_data = d; in_amt = a; in_left = l;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 200);
    if (!in_ready) chk("accept_timeout", 64'd1, 64'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data = {$urandom, $urandom};
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || out_valid) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (sb.size() != 0 || out_valid) chk("drain_timeout", 64'd1, 64'd0);
  endtask

  initial begin
    int n;
    // reset state
    #3;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_sh_din", sh_din, 64'd0);
    chk("rst_sh_samt", 64'(sh_samt), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // short right shift, LO pass amount
    send(64'hFFFF_0000_0000_0000, 6'd8, 1'b0);
    @(negedge clk) chk("t1_samt_lo", 64'(sh_samt), 64'd8);
    drain();
    chk("t1_exp", 64'hFFFF_0000_0000_0000 >> 8, 64'h00FF_FF00_0000_0000);

    // long left shift: 16, 16, 31
    send(64'h1, 6'd63, 1'b1);
    @(negedge clk) chk("t2_samt0", 64'(sh_samt), 64'd16);
    @(negedge clk) chk("t2_samt1", 64'(sh_samt), 64'd16);
    @(negedge clk) chk("t2_samt2", 64'(sh_samt), 64'd31);
    drain();

    // exactly 32 right: LO pass with 0
    send(64'h1234_5678_9ABC_DEF0, 6'd32, 1'b0);
    @(negedge clk) chk("t3_samt0", 64'(sh_samt), 64'd16);
    @(negedge clk) chk("t3_samt1", 64'(sh_samt), 64'd16);
    @(negedge clk) chk("t3_samt2", 64'(sh_samt), 64'd0);
    drain();
    send(64'hA5A5_0F0F_3C3C_9999, 6'd0, 1'b1);
    drain();

    // backpressure
    rdy_force = 1'b0;
    send(64'hDEAD_BEEF_CAFE_F00D, 6'd12, 1'b1);
    in_valid = 1'b1; in_data = 64'h8000_0000_0000_0001; in_amt = 6'd33; in_left = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!out_valid && n < 20);
    chk("bp_valid", 64'(out_valid), 64'd1);
    repeat (5) begin
      @(negedge clk);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_out_valid", 64'(out_valid), 64'd1);
    end
    @(posedge clk); #1 rdy_force = 1'b1;
    @(negedge clk) chk("bp_ready_in_done", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    @(negedge clk) chk("bp_ready_after", 64'(in_ready), 64'd1);
    chk("bp_valid_after", 64'(out_valid), 64'd0);
    @(posedge clk); #1 in_valid = 1'b0;
    drain();

    // reset during HI1 of a 40-bit shift
    send(64'hFFFF_FFFF_FFFF_FFFF, 6'd40, 1'b0);
    @(posedge clk); #1;
    chk("rs_in_hi1", 64'(sh_samt), 64'd16);
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("rs_out_valid", 64'(out_valid), 64'd0);
    chk("rs_in_ready", 64'(in_ready), 64'd1);
    chk("rs_out_data", out_data, 64'd0);
    chk("rs_sh_din", sh_din, 64'd0);
    chk("rs_sh_samt", 64'(sh_samt), 64'd0);
    @(posedge clk); #3 rst_n = 1'b1;
    @(posedge clk); #1;
    repeat (4) @(posedge clk);
    #1 send(64'hFF, 6'd4, 1'b0);
    drain();

    // random traffic with gaps and backpressure
    rdy_rand = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      send({$urandom, $urandom}, 6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)));
    end
    rdy_rand = 1'b0;
    rdy_force = 1'b1;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
